// File: rtl/mig_pkg.sv
// Shared types for the MIG write path: chunk width, chunk type and arbiter states.
package mig_pkg;

  localparam int CHUNK_W = 128;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  typedef logic [CHUNK_W-1:0] chunk_t;

endpackage

// File: rtl/chunk_addr_gen.sv
// Per-source frame-buffer address generator.
// Walks a word offset through one frame, wrapping on tlast or at the last
// chunk of the frame, and flags frames whose length does not match.
module chunk_addr_gen
  import mig_pkg::*;
#(
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned FRAME_CHUNKS = 38400,
  parameter int unsigned BASE         = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              adv,
  input  logic              last,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_err
);

  localparam int unsigned OFF_W = (FRAME_CHUNKS > 1) ? $clog2(FRAME_CHUNKS) : 1;

  if (FRAME_CHUNKS < 1) begin : g_bad_frame_chunks
    $error("chunk_addr_gen: FRAME_CHUNKS must be at least 1");
  end

  if ((64'(BASE) + 64'(FRAME_CHUNKS) - 64'd1) >= (64'd1 << ADDR_W)) begin : g_addr_overflow
    $error("chunk_addr_gen: BASE + FRAME_CHUNKS - 1 does not fit in ADDR_W bits");
  end

  logic [OFF_W-1:0] offset;
  logic             at_end;

  assign at_end = (offset == OFF_W'(FRAME_CHUNKS - 1));
  assign addr   = ADDR_W'(BASE) + ADDR_W'(offset);

  // Offset advances per accepted chunk; the error flag is sticky until reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      offset    <= '0;
      frame_err <= 1'b0;
    end else if (adv) begin
      if (last || at_end) begin
        offset <= '0;
      end else begin
        offset <= offset + 1'b1;
      end
      if (last ^ at_end) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/chunk_write_arbiter.sv
// Round-robin burst arbiter sharing one MIG write path between two chunk
// streams, with a registered output stage and per-source frame addressing.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no input accepted; pick the next source from the valid set
// ARB_BURST | granted source streams up to BURST_LEN chunks or to tlast
module chunk_write_arbiter
  import mig_pkg::*;
#(
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_CHUNKS = 38400,
  parameter int unsigned BASE0        = 0,
  parameter int unsigned BASE1        = 38400
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  chunk_t            s0_tdata,
  input  logic              s0_tlast,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  chunk_t            s1_tdata,
  input  logic              s1_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output chunk_t            m_tdata,
  output logic [ADDR_W-1:0] m_taddr,
  output logic              m_tsrc,
  output logic              m_tlast,
  output logic [1:0]        frame_err
);

  localparam int unsigned BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("chunk_write_arbiter: BURST_LEN must be at least 1");
  end

  arb_state_t        state, state_d;
  logic              grant, grant_d;
  logic              last_grant;
  logic [BC_W-1:0]   burst_cnt;

  logic              out_free;
  logic              sel_valid;
  logic              sel_last;
  chunk_t            sel_data;
  logic              accept;
  logic              burst_end;
  logic [ADDR_W-1:0] addr0, addr1;

  assign out_free  = !m_tvalid || m_tready;
  assign sel_valid = grant ? s1_tvalid : s0_tvalid;
  assign sel_last  = grant ? s1_tlast  : s0_tlast;
  assign sel_data  = grant ? s1_tdata  : s0_tdata;
  assign accept    = (state == ARB_BURST) && sel_valid && out_free;
  // burst_cnt counts down the chunks left in the burst; zero means this is the last one
  assign burst_end = accept && (sel_last || (burst_cnt == '0));

  assign s0_tready = (state == ARB_BURST) && !grant && out_free;
  assign s1_tready = (state == ARB_BURST) &&  grant && out_free;

  // Next-state and grant selection; ties go to the source not served last.
  always_comb begin
    state_d = state;
    grant_d = grant;
    case (state)
      ARB_IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          state_d = ARB_BURST;
          grant_d = (s0_tvalid && s1_tvalid) ? !last_grant : s1_tvalid;
        end
      end
      ARB_BURST: begin
        if (burst_end) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM state, grant history and burst down-counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ARB_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      if (state == ARB_IDLE) begin
        if (state_d == ARB_BURST) begin
          burst_cnt <= BC_W'(BURST_LEN - 1);
        end
      end else if (accept) begin
        burst_cnt <= burst_end ? '0 : burst_cnt - 1'b1;
      end
      if (burst_end) begin
        last_grant <= grant;
      end
    end
  end

  chunk_addr_gen #(
    .ADDR_W       (ADDR_W),
    .FRAME_CHUNKS (FRAME_CHUNKS),
    .BASE         (BASE0)
  ) u_addr0 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .adv       (accept && !grant),
    .last      (s0_tlast),
    .addr      (addr0),
    .frame_err (frame_err[0])
  );

  chunk_addr_gen #(
    .ADDR_W       (ADDR_W),
    .FRAME_CHUNKS (FRAME_CHUNKS),
    .BASE         (BASE1)
  ) u_addr1 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .adv       (accept && grant),
    .last      (s1_tlast),
    .addr      (addr1),
    .frame_err (frame_err[1])
  );

  // Output register: loads on accept, holds under backpressure, empties when drained.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_taddr  <= '0;
      m_tsrc   <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_data;
      m_taddr  <= grant ? addr1 : addr0;
      m_tsrc   <= grant;
      m_tlast  <= sel_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chunk_write_arbiter.sv
// Directed self-checking bench for chunk_write_arbiter.
module tb_chunk_write_arbiter;
  import mig_pkg::*;

  localparam int AW = 27;

  typedef struct {
    logic          src;
    logic [AW-1:0] addr;
    chunk_t        data;
    logic          last;
    int            cyc;
  } rec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  logic s0_tvalid, s0_tready, s0_tlast;
  logic s1_tvalid, s1_tready, s1_tlast;
  chunk_t s0_tdata, s1_tdata, m_tdata;
  logic m_tvalid, m_tready, m_tsrc, m_tlast;
  logic [AW-1:0] m_taddr;
  logic [1:0] frame_err;

  logic e_s0_tvalid, e_s0_tready, e_s0_tlast;
  logic e_s1_tvalid, e_s1_tready, e_s1_tlast;
  chunk_t e_s0_tdata, e_s1_tdata, e_m_tdata;
  logic e_m_tvalid, e_m_tready, e_m_tsrc, e_m_tlast;
  logic [AW-1:0] e_m_taddr;
  logic [1:0] e_frame_err;

  logic [128:0] q0[$];
  logic [128:0] q1[$];
  rec_t out_q[$];
  rec_t mon_r;
  logic acc0, acc1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  chunk_write_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_taddr(m_taddr),
    .m_tsrc(m_tsrc), .m_tlast(m_tlast), .frame_err(frame_err)
  );

  chunk_write_arbiter #(.FRAME_CHUNKS(8), .BASE0(0), .BASE1(8)) dut8 (
    .clk_in(clk_in), .rst_in(rst_in),
    .s0_tvalid(e_s0_tvalid), .s0_tready(e_s0_tready), .s0_tdata(e_s0_tdata), .s0_tlast(e_s0_tlast),
    .s1_tvalid(e_s1_tvalid), .s1_tready(e_s1_tready), .s1_tdata(e_s1_tdata), .s1_tlast(e_s1_tlast),
    .m_tvalid(e_m_tvalid), .m_tready(e_m_tready), .m_tdata(e_m_tdata), .m_taddr(e_m_taddr),
    .m_tsrc(e_m_tsrc), .m_tlast(e_m_tlast), .frame_err(e_frame_err)
  );

  initial forever #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  function automatic chunk_t mk(input int s, input int i);
    return {32'hA5A5_0000 | s, 64'h0, i};
  endfunction

  // Source 0 stacker model: presents the queue head, pops on handshake.
  initial begin
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
    forever begin
      @(negedge clk_in);
      acc0 = s0_tvalid && s0_tready;
      @(posedge clk_in);
      #1;
      if (acc0 && !rst_in && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        s0_tvalid = 1'b1; s0_tdata = q0[0][127:0]; s0_tlast = q0[0][128];
      end else begin
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
      end
    end
  end

  // Source 1 stacker model.
  initial begin
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    forever begin
      @(negedge clk_in);
      acc1 = s1_tvalid && s1_tready;
      @(posedge clk_in);
      #1;
      if (acc1 && !rst_in && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        s1_tvalid = 1'b1; s1_tdata = q1[0][127:0]; s1_tlast = q1[0][128];
      end else begin
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
      end
    end
  end

  // Output monitor: records every command handshake with its cycle number.
  initial forever begin
    @(negedge clk_in);
    if (m_tvalid && m_tready && !rst_in) begin
      mon_r.src = m_tsrc; mon_r.addr = m_taddr; mon_r.data = m_tdata;
      mon_r.last = m_tlast; mon_r.cyc = cyc;
      out_q.push_back(mon_r);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    m_tready = 1'b1;
    q0.delete();
    q1.delete();
    out_q.delete();
    repeat (3) @(posedge clk_in);
  endtask

  task automatic release_rst();
    @(negedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic wait_outs(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && out_q.size() < n; k++) begin
      @(posedge clk_in);
      #2;
    end
    chk(tag, 128'(out_q.size() >= n), 128'(1));
  endtask

  task automatic send8(input logic last, input int exp_addr, input string tag);
    logic got;
    got = 1'b0;
    e_s0_tvalid = 1'b1;
    e_s0_tlast  = last;
    e_s0_tdata  = mk(0, exp_addr);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (e_s0_tready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk_in);
    #1;
    e_s0_tvalid = 1'b0;
    e_s0_tlast  = 1'b0;
    chk({tag, "_acc"}, 128'(got), 128'(1));
    chk({tag, "_addr"}, 128'(e_m_taddr), 128'(exp_addr));
  endtask

  initial begin
    int bad;
    int exp_src, exp_idx, exp_addr;
    logic exp_last;
    chunk_t cap_d;
    logic [AW-1:0] cap_a;

    m_tready = 1'b1;
    e_m_tready = 1'b1;
    e_s0_tvalid = 1'b0; e_s0_tdata = '0; e_s0_tlast = 1'b0;
    e_s1_tvalid = 1'b0; e_s1_tdata = '0; e_s1_tlast = 1'b0;

    // Reset state
    do_reset();
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_m_taddr", 128'(m_taddr), 128'(0));
    chk("rst_m_tdata", m_tdata, 128'(0));
    chk("rst_s0_tready", 128'(s0_tready), 128'(0));
    chk("rst_s1_tready", 128'(s1_tready), 128'(0));
    chk("rst_frame_err", 128'(frame_err), 128'(0));

    // 1: single source, 40 chunks, bubble after chunks 16 and 32
    for (int i = 0; i < 40; i++) q0.push_back({1'b0, mk(0, i)});
    release_rst();
    wait_outs("t1_wait", 40, 300);
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (out_q[i].src !== 1'b0 || out_q[i].addr !== AW'(i) || out_q[i].data !== mk(0, i)) bad++;
    chk("t1_stream", 128'(bad), 128'(0));
    chk("t1_gap16", 128'(out_q[16].cyc - out_q[15].cyc), 128'(2));
    chk("t1_gap32", 128'(out_q[32].cyc - out_q[31].cyc), 128'(2));
    bad = 0;
    for (int i = 1; i < 40; i++)
      if (i != 16 && i != 32 && (out_q[i].cyc - out_q[i-1].cyc) != 1) bad++;
    chk("t1_contig", 128'(bad), 128'(0));
    chk("t1_frame_err", 128'(frame_err), 128'(0));

    // 2: both sources continuously valid, alternating bursts of 16
    do_reset();
    for (int i = 0; i < 32; i++) begin
      q0.push_back({1'b0, mk(0, i)});
      q1.push_back({1'b0, mk(1, i)});
    end
    release_rst();
    wait_outs("t2_wait", 64, 400);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      exp_src  = (k / 16) % 2;
      exp_idx  = (k / 32) * 16 + (k % 16);
      exp_addr = (exp_src == 1) ? 38400 + exp_idx : exp_idx;
      if (out_q[k].src !== exp_src[0] || out_q[k].addr !== AW'(exp_addr) ||
          out_q[k].data !== mk(exp_src, exp_idx)) bad++;
    end
    chk("t2_order", 128'(bad), 128'(0));
    chk("t2_first_src", 128'(out_q[0].src), 128'(0));
    chk("t2_s1_base", 128'(out_q[16].addr), 128'(38400));

    // 3: s1 ends its frame early on the 5th chunk of its burst
    do_reset();
    for (int i = 0; i < 8; i++) q1.push_back({(i == 4), mk(1, i)});
    release_rst();
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 16; i++) q0.push_back({1'b0, mk(0, i)});
    wait_outs("t3_wait", 24, 300);
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 5) begin
        exp_src = 1; exp_idx = k; exp_addr = 38400 + k; exp_last = (k == 4);
      end else if (k < 21) begin
        exp_src = 0; exp_idx = k - 5; exp_addr = k - 5; exp_last = 1'b0;
      end else begin
        exp_src = 1; exp_idx = k - 16; exp_addr = 38400 + (k - 21); exp_last = 1'b0;
      end
      if (out_q[k].src !== exp_src[0] || out_q[k].addr !== AW'(exp_addr) ||
          out_q[k].data !== mk(exp_src, exp_idx) || out_q[k].last !== exp_last) bad++;
    end
    chk("t3_order", 128'(bad), 128'(0));
    chk("t3_tlast", 128'(out_q[4].last), 128'(1));
    chk("t3_next_src", 128'(out_q[5].src), 128'(0));
    chk("t3_s1_restart", 128'(out_q[21].addr), 128'(38400));
    chk("t3_frame_err", 128'(frame_err), 128'(2'b10));

    // 4: backpressure pattern 1,0,0,1 twice inside one burst
    do_reset();
    for (int i = 0; i < 10; i++) q0.push_back({1'b0, mk(0, i)});
    release_rst();
    wait_outs("t4_wait3", 3, 50);
    for (int r = 0; r < 2; r++) begin
      m_tready = 1'b0;
      @(negedge clk_in);
      cap_d = m_tdata;
      cap_a = m_taddr;
      chk($sformatf("t4_hold_valid%0d", r), 128'(m_tvalid), 128'(1));
      chk($sformatf("t4_s0_tready%0d", r), 128'(s0_tready), 128'(0));
      @(posedge clk_in);
      #2;
      @(negedge clk_in);
      chk($sformatf("t4_hold_data%0d", r), m_tdata, cap_d);
      chk($sformatf("t4_hold_addr%0d", r), 128'(m_taddr), 128'(cap_a));
      @(posedge clk_in);
      #2;
      m_tready = 1'b1;
      @(posedge clk_in);
      #2;
    end
    wait_outs("t4_wait10", 10, 100);
    repeat (4) @(posedge clk_in);
    #2;
    chk("t4_count", 128'(out_q.size()), 128'(10));
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (out_q[i].src !== 1'b0 || out_q[i].addr !== AW'(i) || out_q[i].data !== mk(0, i)) bad++;
    chk("t4_scoreboard", 128'(bad), 128'(0));

    // 5: 8-chunk frames on the small build
    do_reset();
    release_rst();
    for (int i = 0; i < 8; i++) send8((i == 7), i, $sformatf("t5_f0_%0d", i));
    chk("t5_err_clean", 128'(e_frame_err), 128'(0));
    for (int i = 0; i < 9; i++) send8(1'b0, i % 8, $sformatf("t5_f1_%0d", i));
    chk("t5_err_set", 128'(e_frame_err), 128'(2'b01));

    // 6: asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 10; i++) q0.push_back({1'b0, mk(0, i)});
    release_rst();
    wait_outs("t6_wait3", 3, 50);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t6_async_valid", 128'(m_tvalid), 128'(0));
    chk("t6_async_addr", 128'(m_taddr), 128'(0));
    q0.delete();
    out_q.delete();
    repeat (2) @(posedge clk_in);
    for (int i = 0; i < 4; i++) q0.push_back({1'b0, mk(0, 100 + i)});
    release_rst();
    wait_outs("t6_wait1", 1, 50);
    chk("t6_first_addr", 128'(out_q[0].addr), 128'(0));
    chk("t6_first_data", out_q[0].data, mk(0, 100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
